cam_emul: RTL and testbench
===========================

CAM_EMUL -- requirements
Module: cam_emul

Interface
REQ-001 Parameter AW, default 15, frame-buffer address width.
REQ-002 Parameter DW, default 12, pixel width, RGB444 {R[11:8],G[7:4],B[3:0]}.
REQ-003 Parameters H_PIX 160, V_LINES 120, H_BLANK 40, VS_LINES 3, VBP_LINES 2, VFP_LINES 2: active pixels per line, active lines, blank pclk per line, vsync, back-porch and front-porch lines.
REQ-004 CAM_pclk  in  1  clock; all registers update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  frame enable; level-sensitive start request.
REQ-007 pat_sel  in  1  source select: 0 = frame buffer, 1 = internal colour bars.
REQ-008 RD_addr  out  AW  frame-buffer read address.
REQ-009 RD_data  in  DW  frame-buffer read data, valid one clock after RD_addr is sampled by the RAM.
REQ-010 CAM_px_data  out  8  camera byte stream.
REQ-011 CAM_vsync  out  1  frame sync, active-high.
REQ-012 CAM_href  out  1  line-valid, active-high.
REQ-013 frame_done  out  1  one-cycle pulse at the end of each frame.

Function
REQ-014 Line length SHALL be L = 2*H_PIX+H_BLANK = 360 pclk; horizontal counter hcnt runs 0..L-1 and wraps to 0.
REQ-015 FSM states SHALL be IDLE, VSYNC, VBACK, ACTIVE, VFRONT; the line counter counts lines within the current state.
REQ-016 IDLE: all outputs at reset values; when en=1, go to VSYNC with hcnt=0.
REQ-017 VSYNC: CAM_vsync=1, CAM_href=0 for VS_LINES*L = 1080 cycles, then VBACK.
REQ-018 VBACK: vsync=0, href=0 for VBP_LINES*L = 720 cycles, then ACTIVE.
REQ-019 ACTIVE: for each of V_LINES lines, CAM_href=1 for hcnt 0..319 and 0 for hcnt 320..359; after line 119, go to VFRONT.
REQ-020 Within href high, pixel x = hcnt/2; even hcnt drives {4'h0, pix[11:8]}, odd hcnt drives pix[7:0].
REQ-021 CAM_px_data SHALL be 8'h00 whenever CAM_href=0.
REQ-022 VFRONT: vsync=0, href=0 for VFP_LINES*L cycles; on its last cycle frame_done=1 for one cycle.
REQ-023 After VFRONT, go to VSYNC if en=1, else IDLE; deasserting en mid-frame SHALL NOT truncate the frame.
REQ-024 Pixel address SHALL be a running counter: 0 at the first pixel of the frame, +1 per pixel, and reset to 0 at each frame start; max value H_PIX*V_LINES-1 = 19199.
REQ-025 RD_addr SHALL carry the address of pixel p at least two cycles before the even byte of p appears; the RAM latency of one clock SHALL be hidden, with no bubbles between pixels or lines.
REQ-026 RD_addr SHALL hold its last value outside ACTIVE and SHALL never exceed 19199.
REQ-027 With pat_sel=1, pix SHALL be bar colour by x/20: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000. RD_data is ignored.
REQ-028 pat_sel SHALL be sampled only at entry to VSYNC and held for the whole frame.
REQ-029 CAM_px_data, CAM_href, CAM_vsync and frame_done SHALL be driven from registers, with no combinational path from inputs.
REQ-030 The byte order and timing SHALL be accepted by the team's capture block: first href byte carries R in bits [3:0], second byte carries G,B.

Reset
REQ-031 On rst=1 at a rising edge: state=IDLE, hcnt=0, line counter=0, pixel address=0, RD_addr=0, CAM_px_data=0, CAM_href=0, CAM_vsync=0, frame_done=0.
REQ-032 rst asserted mid-line or mid-frame SHALL abort immediately. Outputs SHALL be at reset values on the next cycle, and a new frame starts only from IDLE.

Structure
REQ-033 Package cam_pkg SHALL hold the timing constants, frame size 19200, state encoding and the 8 bar colours, shared with the capture block's bench.
REQ-034 One sub-module cam_bar_gen (x in, 12-bit colour out, registered) SHALL implement the colour bars; the counters and FSM stay in cam_emul.

Verification
REQ-035 Reset then en=1: vsync rises 1 cycle later and is high for exactly 1080 cycles; the first href rises 720 cycles after vsync falls.
REQ-036 RAM model data = addr[11:0], pat_sel=0: each line gives 120 href pulses of 320 cycles; pixel 5 bytes are 8'h00, 8'h05; pixel 19199 (12'hAFF) bytes are 8'h0A, 8'hFF.
REQ-037 pat_sel=1: line bytes start 0F,FF for x 0..19; x=20 gives 0F,F0; x=159 gives 00,00; href-low bytes are 00.
REQ-038 Loopback into the capture block with a second RAM: after one frame, all 19200 captured words equal the source; frame_done pulses once.
REQ-039 en dropped during line 50: the frame completes, frame_done pulses, then state returns to IDLE with vsync=0.
REQ-040 rst pulsed at hcnt 100 of line 10: the next cycle has href=0, px_data=0 and RD_addr=0; re-enable gives a full correct frame starting at address 0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants for the camera emulator and its capture-side bench:
// video timing, frame size, FSM state encoding and the colour-bar palette.
package cam_pkg;

    localparam int unsigned CAM_H_PIX     = 160;
    localparam int unsigned CAM_V_LINES   = 120;
    localparam int unsigned CAM_H_BLANK   = 40;
    localparam int unsigned CAM_VS_LINES  = 3;
    localparam int unsigned CAM_VBP_LINES = 2;
    localparam int unsigned CAM_VFP_LINES = 2;

    localparam int unsigned CAM_LINE_LEN  = 2 * CAM_H_PIX + CAM_H_BLANK;
    localparam int unsigned FRAME_PIX     = CAM_H_PIX * CAM_V_LINES;

    localparam int unsigned PIX_W         = 12;
    localparam int unsigned BAR_W         = 20;
    localparam int unsigned NUM_BARS      = 8;
    localparam int unsigned BAR_IDX_W     = $clog2(NUM_BARS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        VFRONT = 3'd4
    } cam_state_e;

    // Bar 0 sits in the low slice: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [NUM_BARS-1:0][PIX_W-1:0] BAR_COLOUR = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F,
        12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

endpackage

// File: rtl/cam_bar_gen.sv
// Colour-bar source: maps a pixel column to one of eight RGB444 bar colours.
// Ports: CAM_pclk/rst (sync, active-high), x = pixel column,
//        colour = registered bar colour for x (one clock of latency, like the RAM).
module cam_bar_gen
    import cam_pkg::*;
#(
    parameter int unsigned XW = 8
)(
    input  logic             CAM_pclk,
    input  logic             rst,
    input  logic [XW-1:0]    x,
    output logic [PIX_W-1:0] colour
);

    logic [BAR_IDX_W-1:0] bar_idx;

    // x / BAR_W as a compare chain
    always_comb begin
        bar_idx = '0;
        for (int unsigned i = 1; i < NUM_BARS; i++) begin
            if (x >= XW'(i * BAR_W)) begin
                bar_idx = BAR_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge CAM_pclk) begin
        if (rst) begin
            colour <= '0;
        end else begin
            colour <= BAR_COLOUR[bar_idx];
        end
    end

endmodule

// File: rtl/cam_emul.sv
// Camera emulator: streams a frame buffer (or colour bars) as an 8-bit
// camera byte stream with vsync/href timing, two bytes per RGB444 pixel.
// Ports: CAM_pclk, rst (sync, active-high), en (frame start request),
//        pat_sel (0 = frame buffer, 1 = bars), RD_addr/RD_data (1-clock RAM),
//        CAM_px_data, CAM_vsync, CAM_href, frame_done (all registered).
module cam_emul
    import cam_pkg::*;
#(
    parameter int unsigned AW        = 15,
    parameter int unsigned DW        = 12,
    parameter int unsigned H_PIX     = CAM_H_PIX,
    parameter int unsigned V_LINES   = CAM_V_LINES,
    parameter int unsigned H_BLANK   = CAM_H_BLANK,
    parameter int unsigned VS_LINES  = CAM_VS_LINES,
    parameter int unsigned VBP_LINES = CAM_VBP_LINES,
    parameter int unsigned VFP_LINES = CAM_VFP_LINES
)(
    input  logic          CAM_pclk,
    input  logic          rst,
    input  logic          en,
    input  logic          pat_sel,
    output logic [AW-1:0] RD_addr,
    input  logic [DW-1:0] RD_data,
    output logic [7:0]    CAM_px_data,
    output logic          CAM_vsync,
    output logic          CAM_href,
    output logic          frame_done
);

    localparam int unsigned LINE_LEN = 2 * H_PIX + H_BLANK;
    localparam int unsigned HCW      = $clog2(LINE_LEN);
    localparam int unsigned LCW      = $clog2(V_LINES + 1);
    localparam int unsigned XW       = $clog2(H_PIX);
    localparam int unsigned PIX_LAST = H_PIX * V_LINES - 1;

    cam_state_e     state, nxt_state;
    logic [HCW-1:0] hcnt, nxt_hcnt;
    logic [LCW-1:0] lcnt, nxt_lcnt;
    logic           line_end;

    logic           pat_q;
    logic [AW-1:0]  pix_addr;
    logic [XW-1:0]  bar_x;
    logic [7:0]     pix_lo;
    logic [PIX_W-1:0] bar_colour;

    logic           nxt_href;
    logic           frame_start;
    logic           prefetch_line;
    logic           fetch_in_line;
    logic           fetch;
    logic [XW-1:0]  fetch_x;
    logic [DW-1:0]  pix_src;

    // FSM and timing counters
    always_ff @(posedge CAM_pclk) begin
        if (rst) begin
            state <= IDLE;
            hcnt  <= '0;
            lcnt  <= '0;
        end else begin
            state <= nxt_state;
            hcnt  <= nxt_hcnt;
            lcnt  <= nxt_lcnt;
        end
    end

    assign line_end = (hcnt == HCW'(LINE_LEN - 1));

    // Next state; lcnt counts lines inside the current state
    always_comb begin
        nxt_state = state;
        nxt_hcnt  = line_end ? '0 : hcnt + HCW'(1);
        nxt_lcnt  = lcnt;
        case (state)
            IDLE: begin
                nxt_hcnt = '0;
                nxt_lcnt = '0;
                if (en) begin
                    nxt_state = VSYNC;
                end
            end
            VSYNC: begin
                if (line_end) begin
                    if (lcnt == LCW'(VS_LINES - 1)) begin
                        nxt_state = VBACK;
                        nxt_lcnt  = '0;
                    end else begin
                        nxt_lcnt  = lcnt + LCW'(1);
                    end
                end
            end
            VBACK: begin
                if (line_end) begin
                    if (lcnt == LCW'(VBP_LINES - 1)) begin
                        nxt_state = ACTIVE;
                        nxt_lcnt  = '0;
                    end else begin
                        nxt_lcnt  = lcnt + LCW'(1);
                    end
                end
            end
            ACTIVE: begin
                if (line_end) begin
                    if (lcnt == LCW'(V_LINES - 1)) begin
                        nxt_state = VFRONT;
                        nxt_lcnt  = '0;
                    end else begin
                        nxt_lcnt  = lcnt + LCW'(1);
                    end
                end
            end
            VFRONT: begin
                if (line_end) begin
                    if (lcnt == LCW'(VFP_LINES - 1)) begin
                        nxt_state = en ? VSYNC : IDLE;
                        nxt_lcnt  = '0;
                    end else begin
                        nxt_lcnt  = lcnt + LCW'(1);
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_hcnt  = '0;
                nxt_lcnt  = '0;
            end
        endcase
    end

    // Output registers are loaded from next-state values, so each output
    // lines up with the state/counter value of the cycle it is visible in.
    assign nxt_href    = (nxt_state == ACTIVE) && (nxt_hcnt < HCW'(2 * H_PIX));
    assign frame_start = (nxt_state == VSYNC) && (state != VSYNC);

    // Pixel x is fetched two cycles ahead of its even byte (hcnt = 2x-2):
    // pixel 0 of each line at hcnt L-2 of the previous line (last VBACK line
    // or any ACTIVE line but the last), the rest on even hcnt in the line.
    assign prefetch_line = (nxt_hcnt == HCW'(LINE_LEN - 2)) &&
                           (((nxt_state == VBACK)  && (nxt_lcnt == LCW'(VBP_LINES - 1))) ||
                            ((nxt_state == ACTIVE) && (nxt_lcnt != LCW'(V_LINES - 1))));
    assign fetch_in_line = (nxt_state == ACTIVE) && !nxt_hcnt[0] &&
                           (nxt_hcnt <= HCW'(2 * H_PIX - 4));
    assign fetch         = prefetch_line || fetch_in_line;
    assign fetch_x       = prefetch_line ? '0 : XW'(nxt_hcnt >> 1) + XW'(1);

    // RAM data and bar colour both arrive one clock after the fetch
    assign pix_src = pat_q ? DW'(bar_colour) : RD_data;

    cam_bar_gen #(
        .XW (XW)
    ) u_bar_gen (
        .CAM_pclk (CAM_pclk),
        .rst      (rst),
        .x        (bar_x),
        .colour   (bar_colour)
    );

    // Address pipeline, source select and byte serialiser
    always_ff @(posedge CAM_pclk) begin
        if (rst) begin
            pat_q       <= 1'b0;
            pix_addr    <= '0;
            RD_addr     <= '0;
            bar_x       <= '0;
            pix_lo      <= '0;
            CAM_px_data <= 8'h00;
            CAM_vsync   <= 1'b0;
            CAM_href    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            CAM_vsync  <= (nxt_state == VSYNC);
            CAM_href   <= nxt_href;
            frame_done <= (nxt_state == VFRONT) &&
                          (nxt_lcnt == LCW'(VFP_LINES - 1)) &&
                          (nxt_hcnt == HCW'(LINE_LEN - 1));

            if (frame_start) begin
                pat_q    <= pat_sel;
                pix_addr <= '0;
            end else if (fetch) begin
                RD_addr <= pix_addr;
                bar_x   <= fetch_x;
                if (pix_addr != AW'(PIX_LAST)) begin
                    pix_addr <= pix_addr + AW'(1);
                end
            end

            if (nxt_href) begin
                if (!nxt_hcnt[0]) begin
                    CAM_px_data <= {4'h0, pix_src[11:8]};
                    pix_lo      <= pix_src[7:0];
                end else begin
                    CAM_px_data <= pix_lo;
                end
            end else begin
                CAM_px_data <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_cam_emul.sv
// Directed bench for cam_emul: reset, frame timing, frame-buffer frame with
// en dropped mid-frame, colour bars, and a mid-line reset with restart.
module tb_cam_emul;

    localparam int FRAME = 19200;

    logic        CAM_pclk;
    logic        rst;
    logic        en;
    logic        pat_sel;
    logic [14:0] RD_addr;
    logic [11:0] RD_data;
    logic [7:0]  CAM_px_data;
    logic        CAM_vsync;
    logic        CAM_href;
    logic        frame_done;

    int n_cmp;
    int n_err;

    // capture monitor state (written only by the monitor)
    logic        mon_clear;
    logic [7:0]  cap_hi [FRAME];
    logic [7:0]  cap_lo [FRAME];
    int          cap_cnt;
    int          href_pulses;
    int          bad_len;
    int          run_len;
    int          fd_cnt;
    int          idle_bad;

    cam_emul dut (
        .CAM_pclk    (CAM_pclk),
        .rst         (rst),
        .en          (en),
        .pat_sel     (pat_sel),
        .RD_addr     (RD_addr),
        .RD_data     (RD_data),
        .CAM_px_data (CAM_px_data),
        .CAM_vsync   (CAM_vsync),
        .CAM_href    (CAM_href),
        .frame_done  (frame_done)
    );

    initial CAM_pclk = 1'b0;
    always #5 CAM_pclk = ~CAM_pclk;

    // frame-buffer RAM model: one clock read latency, data = addr[11:0]
    always @(posedge CAM_pclk) RD_data <= RD_addr[11:0];

    // capture block model: reassembles pixel bytes and measures href pulses
    always @(negedge CAM_pclk) begin
        if (mon_clear) begin
            cap_cnt = 0; href_pulses = 0; bad_len = 0;
            run_len = 0; fd_cnt = 0; idle_bad = 0;
        end else begin
            if (CAM_href === 1'b1) begin
                if (cap_cnt < 2 * FRAME) begin
                    if (cap_cnt % 2 == 0) cap_hi[cap_cnt / 2] = CAM_px_data;
                    else                  cap_lo[cap_cnt / 2] = CAM_px_data;
                end
                cap_cnt = cap_cnt + 1;
                run_len = run_len + 1;
            end else begin
                if (run_len != 0) begin
                    href_pulses = href_pulses + 1;
                    if (run_len != 320) bad_len = bad_len + 1;
                    run_len = 0;
                end
                if (CAM_px_data !== 8'h00) idle_bad = idle_bad + 1;
            end
            if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge CAM_pclk);
        #1;
    endtask

    function automatic logic [11:0] exp_bar(int x);
        case (x / 20)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; pat_sel = 1'b0; mon_clear = 1'b1;
        repeat (3) tick();
        n_cmp++; if (CAM_vsync !== 1'b0) begin n_err++; $display("FAIL reset_vsync: got %b expected 0", CAM_vsync); end
        n_cmp++; if (CAM_href !== 1'b0) begin n_err++; $display("FAIL reset_href: got %b expected 0", CAM_href); end
        n_cmp++; if (CAM_px_data !== 8'h00) begin n_err++; $display("FAIL reset_px: got %h expected 00", CAM_px_data); end
        n_cmp++; if (RD_addr !== 15'd0) begin n_err++; $display("FAIL reset_addr: got %0d expected 0", RD_addr); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", frame_done); end
        rst = 1'b0;
        repeat (5) tick();
        n_cmp++; if (CAM_vsync !== 1'b0) begin n_err++; $display("FAIL idle_no_en: vsync got %b expected 0", CAM_vsync); end
        mon_clear = 1'b0;
    endtask

    task automatic test_frame_ram();
        int n;
        int errs;
        logic [11:0] w;
        mon_clear = 1'b1; tick(); mon_clear = 1'b0;
        pat_sel = 1'b0; en = 1'b1;
        tick();
        n_cmp++; if (CAM_vsync !== 1'b1) begin n_err++; $display("FAIL vsync_rise: got %b expected 1", CAM_vsync); end
        n = 0;
        while (CAM_vsync === 1'b1 && n < 2000) begin n++; tick(); end
        n_cmp++; if (n != 1080) begin n_err++; $display("FAIL vsync_width: got %0d expected 1080", n); end
        n = 0;
        while (CAM_href !== 1'b1 && n < 2000) begin n++; tick(); end
        n_cmp++; if (n != 720) begin n_err++; $display("FAIL href_delay: got %0d expected 720", n); end

        // drop en during active line 50; frame must still complete
        n = 0;
        while (!(href_pulses >= 50 && CAM_href === 1'b1) && n < 30000) begin n++; tick(); end
        n_cmp++; if (href_pulses != 50) begin n_err++; $display("FAIL reach_line50: got %0d expected 50", href_pulses); end
        en = 1'b0;
        n = 0;
        while (frame_done !== 1'b1 && n < 60000) begin n++; tick(); end
        n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL frame_done_seen: got %b expected 1", frame_done); end
        repeat (3) tick();

        n_cmp++; if (cap_cnt != 2 * FRAME) begin n_err++; $display("FAIL byte_count: got %0d expected %0d", cap_cnt, 2 * FRAME); end
        n_cmp++; if (href_pulses != 120) begin n_err++; $display("FAIL href_pulses: got %0d expected 120", href_pulses); end
        n_cmp++; if (bad_len != 0) begin n_err++; $display("FAIL href_len: got %0d bad pulses expected 0", bad_len); end
        n_cmp++; if (idle_bad != 0) begin n_err++; $display("FAIL idle_px: got %0d nonzero bytes expected 0", idle_bad); end
        n_cmp++; if (fd_cnt != 1) begin n_err++; $display("FAIL done_pulses: got %0d expected 1", fd_cnt); end
        n_cmp++; if (cap_hi[5] !== 8'h00 || cap_lo[5] !== 8'h05) begin n_err++; $display("FAIL pix5: got %h %h expected 00 05", cap_hi[5], cap_lo[5]); end
        n_cmp++; if (cap_hi[19199] !== 8'h0A || cap_lo[19199] !== 8'hFF) begin n_err++; $display("FAIL pix19199: got %h %h expected 0A FF", cap_hi[19199], cap_lo[19199]); end
        errs = 0;
        for (int p = 0; p < FRAME; p++) begin
            w = 12'(p);
            if (cap_hi[p] !== {4'h0, w[11:8]} || cap_lo[p] !== w[7:0]) errs++;
        end
        n_cmp++; if (errs != 0) begin n_err++; $display("FAIL frame_words: got %0d bad pixels expected 0", errs); end
        n_cmp++; if (RD_addr !== 15'd19199) begin n_err++; $display("FAIL addr_hold: got %0d expected 19199", RD_addr); end
        repeat (400) tick();
        n_cmp++; if (CAM_vsync !== 1'b0 || CAM_href !== 1'b0) begin n_err++; $display("FAIL back_to_idle: got vs=%b hr=%b expected 0 0", CAM_vsync, CAM_href); end
        n_cmp++; if (RD_addr !== 15'd19199) begin n_err++; $display("FAIL addr_idle: got %0d expected 19199", RD_addr); end
    endtask

    task automatic test_pattern();
        int n;
        int errs;
        logic [11:0] c;
        mon_clear = 1'b1; tick(); mon_clear = 1'b0;
        pat_sel = 1'b1; en = 1'b1;
        tick();
        // change after VSYNC entry must not affect this frame
        pat_sel = 1'b0;
        n = 0;
        while (href_pulses < 10 && n < 10000) begin n++; tick(); end
        n_cmp++; if (cap_cnt != 3200) begin n_err++; $display("FAIL bar_bytes: got %0d expected 3200", cap_cnt); end
        n_cmp++; if (cap_hi[0] !== 8'h0F || cap_lo[0] !== 8'hFF) begin n_err++; $display("FAIL bar_x0: got %h %h expected 0F FF", cap_hi[0], cap_lo[0]); end
        n_cmp++; if (cap_hi[20] !== 8'h0F || cap_lo[20] !== 8'hF0) begin n_err++; $display("FAIL bar_x20: got %h %h expected 0F F0", cap_hi[20], cap_lo[20]); end
        n_cmp++; if (cap_hi[159] !== 8'h00 || cap_lo[159] !== 8'h00) begin n_err++; $display("FAIL bar_x159: got %h %h expected 00 00", cap_hi[159], cap_lo[159]); end
        errs = 0;
        for (int p = 0; p < 1600; p++) begin
            c = exp_bar(p % 160);
            if (cap_hi[p] !== {4'h0, c[11:8]} || cap_lo[p] !== c[7:0]) errs++;
        end
        n_cmp++; if (errs != 0) begin n_err++; $display("FAIL bar_lines: got %0d bad pixels expected 0", errs); end
        n_cmp++; if (idle_bad != 0) begin n_err++; $display("FAIL bar_idle_px: got %0d nonzero bytes expected 0", idle_bad); end
    endtask

    task automatic test_reset_midframe();
        int n;
        int errs;
        logic [11:0] w;
        // continue the bar frame into line 10, then reset at hcnt 100
        n = 0;
        while (CAM_href !== 1'b1 && n < 1000) begin n++; tick(); end
        repeat (100) tick();
        rst = 1'b1; en = 1'b0;
        tick();
        n_cmp++; if (CAM_href !== 1'b0) begin n_err++; $display("FAIL rst_href: got %b expected 0", CAM_href); end
        n_cmp++; if (CAM_px_data !== 8'h00) begin n_err++; $display("FAIL rst_px: got %h expected 00", CAM_px_data); end
        n_cmp++; if (RD_addr !== 15'd0) begin n_err++; $display("FAIL rst_addr: got %0d expected 0", RD_addr); end
        rst = 1'b0;
        mon_clear = 1'b1; tick(); mon_clear = 1'b0;
        n_cmp++; if (CAM_vsync !== 1'b0) begin n_err++; $display("FAIL rst_stays_idle: vsync got %b expected 0", CAM_vsync); end

        en = 1'b1;
        n = 0;
        while (href_pulses < 2 && n < 5000) begin n++; tick(); end
        en = 1'b0;
        n_cmp++; if (cap_cnt != 640) begin n_err++; $display("FAIL restart_bytes: got %0d expected 640", cap_cnt); end
        errs = 0;
        for (int p = 0; p < 320; p++) begin
            w = 12'(p);
            if (cap_hi[p] !== {4'h0, w[11:8]} || cap_lo[p] !== w[7:0]) errs++;
        end
        n_cmp++; if (errs != 0) begin n_err++; $display("FAIL restart_words: got %0d bad pixels expected 0", errs); end
        n_cmp++; if (bad_len != 0) begin n_err++; $display("FAIL restart_href_len: got %0d bad pulses expected 0", bad_len); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_frame_ram();
        test_pattern();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
